// File: rtl/udp_img_rx_parser.sv
// Receive-side image parser: validates the 32-byte UDP image header and repacks
// B,G,R payload bytes into {R,G,B,8'h00} pixel words for the SDRAM write FIFO.
module udp_img_rx_parser #(
    parameter logic [31:0] MAGIC       = 32'hAA0055FF,
    parameter int          IMG_WIDTH   = 640,
    parameter int          IMG_HEIGHT  = 480,
    parameter int          FRAME_SIZE  = 636,
    parameter int          LAST_SIZE   = 36,
    parameter int          FRAME_TOTAL = 1450
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_app_rx_data_valid,
    input  logic [7:0]  i_app_rx_data,
    input  logic [15:0] i_app_rx_data_length,
    output logic        o_write_req,
    input  logic        i_write_req_ack,
    output logic        o_write_en,
    output logic [31:0] o_write_data,
    output logic        o_pic_done,
    output logic [31:0] o_pic_seq_out,
    output logic        o_err_magic,
    output logic        o_err_len,
    output logic        o_err_seq,
    output logic [15:0] o_pkt_drop_cnt
);

    // state    | meaning
    // S_IDLE   | waiting for byte 0 of a packet
    // S_HEADER | collecting header bytes 1..31, validated on byte 31
    // S_PAYLOAD| repacking B,G,R triplets into pixel words
    // S_DISCARD| swallowing the rest of a rejected packet
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_DISCARD} state_t;

    localparam logic [31:0] LP_WIDTH      = 32'(IMG_WIDTH);
    localparam logic [31:0] LP_HEIGHT     = 32'(IMG_HEIGHT);
    localparam logic [31:0] LP_FRAME_SIZE = 32'(FRAME_SIZE);
    localparam logic [31:0] LP_LAST_SIZE  = 32'(LAST_SIZE);
    localparam logic [31:0] LP_LAST_SEQ   = 32'(FRAME_TOTAL - 1);

    state_t r_state, w_state_nxt;

    logic [15:0]  r_byte_cnt;
    logic [247:0] r_hdr;
    logic [1:0]   r_byte_sel;
    logic [7:0]   r_b;
    logic [7:0]   r_g;
    logic         r_in_pic;
    logic [31:0]  r_exp_seq;
    logic         r_cur_last;
    logic [31:0]  r_pic_seq;

    logic         r_write_req;
    logic         r_write_en;
    logic [31:0]  r_write_data;
    logic         r_pic_done;
    logic [31:0]  r_pic_seq_out;
    logic         r_err_magic;
    logic         r_err_len;
    logic         r_err_seq;
    logic [15:0]  r_drop_cnt;

    logic [255:0] w_hdr;
    logic [31:0]  w_magic, w_width, w_height, w_picseq, w_framseq, w_w7;
    logic [16:0]  w_cnt_inc;
    logic         w_pkt_end;
    logic         w_last_frame;
    logic [31:0]  w_exp_size;
    logic         w_bad_magic, w_bad_len, w_seq_start, w_seq_next;
    logic         w_err_magic, w_err_len, w_err_seq, w_accept, w_drop;

    // Byte 31 is still on the bus during validation, so it completes W7 directly.
    assign w_hdr     = {i_app_rx_data, r_hdr};
    assign w_magic   = w_hdr[31:0];
    assign w_width   = w_hdr[63:32];
    assign w_height  = w_hdr[95:64];
    assign w_picseq  = w_hdr[191:160];
    assign w_framseq = w_hdr[223:192];
    assign w_w7      = w_hdr[255:224];

    assign w_cnt_inc = {1'b0, r_byte_cnt} + 17'd1;
    assign w_pkt_end = i_app_rx_data_valid && (w_cnt_inc >= {1'b0, i_app_rx_data_length});

    assign w_last_frame = (w_framseq == LP_LAST_SEQ);
    assign w_exp_size   = w_last_frame ? LP_LAST_SIZE : LP_FRAME_SIZE;
    assign w_bad_magic  = (w_magic != MAGIC) || (w_width != LP_WIDTH) || (w_height != LP_HEIGHT);
    assign w_bad_len    = (w_w7 != w_exp_size) ||
                          ((w_w7 + 32'd32) != {16'd0, i_app_rx_data_length});
    assign w_seq_start  = (w_framseq == 32'd0);
    assign w_seq_next   = r_in_pic && (w_framseq == r_exp_seq);

    always_comb begin
        w_state_nxt = r_state;
        w_err_magic = 1'b0;
        w_err_len   = 1'b0;
        w_err_seq   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_app_rx_data_valid) begin
                    if (i_app_rx_data_length < 16'd32) begin
                        w_err_len   = 1'b1;
                        w_state_nxt = w_pkt_end ? S_IDLE : S_DISCARD;
                    end else begin
                        w_state_nxt = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (i_app_rx_data_valid && (r_byte_cnt == 16'd31)) begin
                    if (w_bad_magic)
                        w_err_magic = 1'b1;
                    else if (w_bad_len)
                        w_err_len = 1'b1;
                    else if (!(w_seq_start || w_seq_next))
                        w_err_seq = 1'b1;
                    else
                        w_accept = 1'b1;
                    if (w_pkt_end)
                        w_state_nxt = S_IDLE;
                    else
                        w_state_nxt = w_accept ? S_PAYLOAD : S_DISCARD;
                end
            end
            S_PAYLOAD: begin
                if (w_pkt_end)
                    w_state_nxt = S_IDLE;
            end
            S_DISCARD: begin
                if (w_pkt_end)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_drop = w_err_magic || w_err_len || w_err_seq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt    <= '0;
            r_hdr         <= '0;
            r_byte_sel    <= '0;
            r_b           <= '0;
            r_g           <= '0;
            r_in_pic      <= 1'b0;
            r_exp_seq     <= '0;
            r_cur_last    <= 1'b0;
            r_pic_seq     <= '0;
            r_write_req   <= 1'b0;
            r_write_en    <= 1'b0;
            r_write_data  <= '0;
            r_pic_done    <= 1'b0;
            r_pic_seq_out <= '0;
            r_err_magic   <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_seq     <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_write_en  <= 1'b0;
            r_pic_done  <= 1'b0;
            r_err_magic <= w_err_magic;
            r_err_len   <= w_err_len;
            r_err_seq   <= w_err_seq;

            if (i_app_rx_data_valid)
                r_byte_cnt <= w_pkt_end ? 16'd0 : w_cnt_inc[15:0];

            if (i_app_rx_data_valid && ((r_state == S_IDLE) || (r_state == S_HEADER)))
                r_hdr <= w_hdr[255:8];

            if (w_drop && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;

            if (w_err_seq)
                r_in_pic <= 1'b0;

            if (w_accept) begin
                r_byte_sel <= 2'd0;
                r_cur_last <= w_last_frame;
                if (w_seq_start) begin
                    r_in_pic  <= 1'b1;
                    r_exp_seq <= 32'd1;
                    r_pic_seq <= w_picseq;
                end else begin
                    r_exp_seq <= r_exp_seq + 32'd1;
                end
            end

            // A new picture request takes precedence over an ack in the same cycle.
            if (w_accept && w_seq_start)
                r_write_req <= 1'b1;
            else if (i_write_req_ack)
                r_write_req <= 1'b0;

            if ((r_state == S_PAYLOAD) && i_app_rx_data_valid) begin
                case (r_byte_sel)
                    2'd0: begin
                        r_b        <= i_app_rx_data;
                        r_byte_sel <= 2'd1;
                    end
                    2'd1: begin
                        r_g        <= i_app_rx_data;
                        r_byte_sel <= 2'd2;
                    end
                    2'd2: begin
                        r_write_data <= {i_app_rx_data, r_g, r_b, 8'h00};
                        r_write_en   <= 1'b1;
                        r_byte_sel   <= 2'd0;
                    end
                    default: r_byte_sel <= 2'd0;
                endcase
                if (w_pkt_end && r_cur_last) begin
                    r_pic_done    <= 1'b1;
                    r_pic_seq_out <= r_pic_seq;
                    r_in_pic      <= 1'b0;
                end
            end
        end
    end

    assign o_write_req    = r_write_req;
    assign o_write_en     = r_write_en;
    assign o_write_data   = r_write_data;
    assign o_pic_done     = r_pic_done;
    assign o_pic_seq_out  = r_pic_seq_out;
    assign o_err_magic    = r_err_magic;
    assign o_err_len      = r_err_len;
    assign o_err_seq      = r_err_seq;
    assign o_pkt_drop_cnt = r_drop_cnt;

endmodule
